// File: rtl/rx_bit_unstuffer_pkg.sv
// Shared types for the low-speed USB receive bit stage: line states, receiver FSM states
// and the decode helper that maps the D+/D- pair onto a line state.
package usb_pkg;

  localparam int CLKS_PER_BIT = 32;

  // Encodings match {d_plus, d_minus} so the decode is a direct cast.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SYNC = 2'b01,
    ST_DATA = 2'b10,
    ST_ERR  = 2'b11
  } rx_state_e;

  function automatic line_state_e to_line_state(input logic d_plus, input logic d_minus);
    return line_state_e'({d_plus, d_minus});
  endfunction

endpackage

// File: rtl/rx_bit_unstuffer_if.sv
// Bundle between the line/recovery side and the packet layer for rx_bit_unstuffer.
// The slave modport is the receiver's view; master is the environment driving the line.
interface rx_bit_unstuffer_if;

  logic       d_plus;
  logic       d_minus;
  logic       pulse;
  logic       rx_eop;
  logic       rx_active;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_pkt_end;
  logic       rx_align_err;
  logic       rx_stuff_err;

  modport slave (
    input  d_plus,
    input  d_minus,
    input  pulse,
    input  rx_eop,
    output rx_active,
    output rx_byte,
    output rx_byte_valid,
    output rx_pkt_end,
    output rx_align_err,
    output rx_stuff_err
  );

  modport master (
    output d_plus,
    output d_minus,
    output pulse,
    output rx_eop,
    input  rx_active,
    input  rx_byte,
    input  rx_byte_valid,
    input  rx_pkt_end,
    input  rx_align_err,
    input  rx_stuff_err
  );

endinterface

// File: rtl/rx_bit_unstuffer_nrzi.sv
// NRZI decoder: samples the line on each bit-centre pulse and compares J/K samples with
// the previous J/K sample. Outputs are combinational in the pulse cycle.
module nrzi_decoder
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  input  logic d_plus,
  input  logic d_minus,
  input  logic clear,
  output logic dec_bit,
  output logic dec_valid,
  output logic dec_se1
);

  line_state_e ref_q;
  line_state_e ref_d;
  line_state_e line_s;

  assign line_s = to_line_state(d_plus, d_minus);

  always_comb begin
    ref_d     = ref_q;
    dec_bit   = 1'b0;
    dec_valid = 1'b0;
    dec_se1   = 1'b0;
    if (pulse) begin
      case (line_s)
        LS_J, LS_K: begin
          dec_valid = 1'b1;
          dec_bit   = (line_s == ref_q);
          ref_d     = line_s;
        end
        LS_SE1:  dec_se1 = 1'b1;
        default: ;
      endcase
    end
    // Packet boundaries always restart decoding from the idle (J) level.
    if (clear) begin
      ref_d = LS_J;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= LS_J;
    end else begin
      ref_q <= ref_d;
    end
  end

endmodule

// File: rtl/rx_bit_unstuffer.sv
// Receive bit stage: SYNC hunt, bit unstuffing, LSB-first byte assembly and packet-end
// reporting on top of the NRZI decoder.
module rx_bit_unstuffer
  import usb_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 3,
  parameter int STUFF_LEN      = 6
) (
  input  logic                clk,
  input  logic                rst,
  rx_bit_unstuffer_if.slave   bus
);

  localparam int         OW        = $clog2(STUFF_LEN + 1);
  localparam logic [2:0] SYNC_MIN  = 3'(SYNC_MIN_ZEROS);
  localparam logic [OW-1:0] STUFF_CNT = OW'(STUFF_LEN);

  rx_state_e     state_q, state_d;
  logic [2:0]    zero_cnt_q, zero_cnt_d;
  logic [OW-1:0] ones_cnt_q, ones_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_byte_valid_q, rx_byte_valid_d;
  logic          rx_active_q, rx_active_d;
  logic          rx_pkt_end_q, rx_pkt_end_d;
  logic          rx_align_err_q, rx_align_err_d;
  logic          rx_stuff_err_q, rx_stuff_err_d;

  logic dec_bit;
  logic dec_valid;
  logic dec_se1;
  logic ref_clear;

  nrzi_decoder u_nrzi (
    .clk       (clk),
    .rst       (rst),
    .pulse     (bus.pulse),
    .d_plus    (bus.d_plus),
    .d_minus   (bus.d_minus),
    .clear     (ref_clear),
    .dec_bit   (dec_bit),
    .dec_valid (dec_valid),
    .dec_se1   (dec_se1)
  );

  always_comb begin
    state_d         = state_q;
    zero_cnt_d      = zero_cnt_q;
    ones_cnt_d      = ones_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    rx_byte_d       = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    rx_pkt_end_d    = 1'b0;
    rx_align_err_d  = 1'b0;
    rx_stuff_err_d  = 1'b0;
    ref_clear       = 1'b0;

    // End of packet takes priority over any bit sampled in the same cycle.
    if (bus.rx_eop) begin
      if (state_q != ST_IDLE) begin
        ref_clear  = 1'b1;
        state_d    = ST_IDLE;
        zero_cnt_d = '0;
        ones_cnt_d = '0;
        bit_cnt_d  = '0;
        shift_d    = '0;
        if (state_q != ST_SYNC) begin
          rx_pkt_end_d   = 1'b1;
          rx_align_err_d = (state_q == ST_DATA) && (bit_cnt_q != 3'd0);
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dec_valid && !dec_bit) begin
            state_d    = ST_SYNC;
            zero_cnt_d = 3'd1;
          end
        end
        ST_SYNC: begin
          if (dec_se1) begin
            state_d        = ST_ERR;
            rx_stuff_err_d = 1'b1;
          end else if (dec_valid) begin
            if (!dec_bit) begin
              if (zero_cnt_q != 3'd7) begin
                zero_cnt_d = zero_cnt_q + 3'd1;
              end
            end else if (zero_cnt_q >= SYNC_MIN) begin
              state_d    = ST_DATA;
              ones_cnt_d = OW'(1);
              bit_cnt_d  = '0;
              shift_d    = '0;
              zero_cnt_d = '0;
            end else begin
              state_d    = ST_IDLE;
              zero_cnt_d = '0;
              ref_clear  = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (dec_se1) begin
            state_d        = ST_ERR;
            rx_stuff_err_d = 1'b1;
          end else if (dec_valid) begin
            if (ones_cnt_q == STUFF_CNT) begin
              if (!dec_bit) begin
                ones_cnt_d = '0;
              end else begin
                state_d        = ST_ERR;
                rx_stuff_err_d = 1'b1;
              end
            end else begin
              shift_d    = {dec_bit, shift_q[7:1]};
              bit_cnt_d  = bit_cnt_q + 3'd1;
              ones_cnt_d = dec_bit ? (ones_cnt_q + OW'(1)) : '0;
              if (bit_cnt_q == 3'd7) begin
                rx_byte_d       = {dec_bit, shift_q[7:1]};
                rx_byte_valid_d = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end

    rx_active_d = (state_d == ST_DATA) || (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      zero_cnt_q      <= '0;
      ones_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      rx_active_q     <= 1'b0;
      rx_pkt_end_q    <= 1'b0;
      rx_align_err_q  <= 1'b0;
      rx_stuff_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      zero_cnt_q      <= zero_cnt_d;
      ones_cnt_q      <= ones_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      rx_active_q     <= rx_active_d;
      rx_pkt_end_q    <= rx_pkt_end_d;
      rx_align_err_q  <= rx_align_err_d;
      rx_stuff_err_q  <= rx_stuff_err_d;
    end
  end

  assign bus.rx_active     = rx_active_q;
  assign bus.rx_byte       = rx_byte_q;
  assign bus.rx_byte_valid = rx_byte_valid_q;
  assign bus.rx_pkt_end    = rx_pkt_end_q;
  assign bus.rx_align_err  = rx_align_err_q;
  assign bus.rx_stuff_err  = rx_stuff_err_q;

endmodule

// File: tb/tb_rx_bit_unstuffer.sv
// Directed bench for rx_bit_unstuffer: NRZI-encodes hand-written bit streams onto the line
// and compares strobes and bytes against hand-computed values.
module tb_rx_bit_unstuffer;
  import usb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_bit_unstuffer_if bus ();

  rx_bit_unstuffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  byte_q[$];
  int          pkt_end_n = 0;
  int          align_n   = 0;
  int          stuff_n   = 0;
  line_state_e cur       = LS_J;

  int b0, p0, a0, s0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("check %s: got=%0h", tag, got);
    end
  endtask

  // Strobe recorder, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_byte_valid) begin
        byte_q.push_back(bus.rx_byte);
        $display("byte %02h", bus.rx_byte);
      end
      if (bus.rx_pkt_end)   pkt_end_n++;
      if (bus.rx_align_err) align_n++;
      if (bus.rx_stuff_err) stuff_n++;
    end
  end

  task automatic drive_line(input line_state_e ls);
    {bus.d_plus, bus.d_minus} = ls;
  endtask

  // One bit period: idle gap, then a one-cycle pulse; returns at the negedge after the pulse.
  task automatic sym(input line_state_e ls, input logic eop);
    repeat (CLKS_PER_BIT - 1) @(negedge clk);
    drive_line(ls);
    bus.pulse  = 1'b1;
    bus.rx_eop = eop;
    @(negedge clk);
    bus.pulse  = 1'b0;
    bus.rx_eop = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic eop);
    if (!b) cur = (cur == LS_J) ? LS_K : LS_J;
    sym(cur, eop);
  endtask

  // Sends v[n-1] first, so literals read left to right in time order.
  task automatic send_seq(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

  task automatic do_eop(input int hold);
    sym(LS_SE0, 1'b0);
    sym(LS_SE0, 1'b0);
    bus.rx_eop = 1'b1;
    repeat (hold) @(negedge clk);
    bus.rx_eop = 1'b0;
    cur = LS_J;
    drive_line(LS_J);
  endtask

  task automatic snap();
    @(negedge clk);
    b0 = byte_q.size();
    p0 = pkt_end_n;
    a0 = align_n;
    s0 = stuff_n;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs_zero_vec();
    return {bus.rx_active, bus.rx_byte_valid, bus.rx_pkt_end, bus.rx_align_err,
            bus.rx_stuff_err, |bus.rx_byte};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    bus.pulse  = 1'b0;
    bus.rx_eop = 1'b0;
    drive_line(LS_J);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'(outs_zero_vec()), 32'h0);

    // Basic packet: SYNC, 0xA5, EOP held three cycles.
    snap();
    send_seq(64'b00000001, 8);
    check("t1_active_after_sync", 32'(bus.rx_active), 32'h1);
    send_seq(64'b10100101, 8);
    check("t1_valid_strobe", 32'(bus.rx_byte_valid), 32'h1);
    check("t1_byte", 32'(bus.rx_byte), 32'hA5);
    @(negedge clk);
    check("t1_valid_one_cycle", 32'(bus.rx_byte_valid), 32'h0);
    do_eop(3);
    settle();
    check("t1_nbytes", 32'(byte_q.size() - b0), 32'd1);
    check("t1_pkt_end_once", 32'(pkt_end_n - p0), 32'd1);
    check("t1_align", 32'(align_n - a0), 32'd0);
    check("t1_stuff", 32'(stuff_n - s0), 32'd0);
    check("t1_active_after_eop", 32'(bus.rx_active), 32'h0);

    // 0xFF, 0x3F with two stuffed zeros removed.
    snap();
    send_seq(64'b00000001, 8);
    send_seq(64'b111110111_111011100, 18);
    do_eop(1);
    settle();
    check("t2_nbytes", 32'(byte_q.size() - b0), 32'd2);
    if (byte_q.size() - b0 == 2) begin
      check("t2_byte0", 32'(byte_q[b0]), 32'hFF);
      check("t2_byte1", 32'(byte_q[b0 + 1]), 32'h3F);
    end
    check("t2_align", 32'(align_n - a0), 32'd0);
    check("t2_stuff", 32'(stuff_n - s0), 32'd0);

    // Stuff violation: seventh consecutive 1 (SYNC's last 1 counts).
    snap();
    send_seq(64'b00000001, 8);
    send_seq(64'b111111, 6);
    check("t3_stuff_strobe", 32'(bus.rx_stuff_err), 32'h1);
    send_seq(64'b1010101010, 10);
    settle();
    check("t3_active_in_err", 32'(bus.rx_active), 32'h1);
    check("t3_no_bytes", 32'(byte_q.size() - b0), 32'd0);
    check("t3_stuff_count", 32'(stuff_n - s0), 32'd1);
    do_eop(1);
    settle();
    check("t3_pkt_end", 32'(pkt_end_n - p0), 32'd1);
    check("t3_align", 32'(align_n - a0), 32'd0);
    check("t3_active_after_eop", 32'(bus.rx_active), 32'h0);

    // 11 data bits: one byte 0xCC then misaligned EOP.
    snap();
    send_seq(64'b00000001, 8);
    send_seq(64'b00110011_101, 11);
    do_eop(2);
    settle();
    check("t4_nbytes", 32'(byte_q.size() - b0), 32'd1);
    if (byte_q.size() - b0 == 1) check("t4_byte", 32'(byte_q[b0]), 32'hCC);
    check("t4_pkt_end", 32'(pkt_end_n - p0), 32'd1);
    check("t4_align_err", 32'(align_n - a0), 32'd1);

    // Truncated SYNC: K J J = two zeros then a 1, rejected.
    snap();
    send_seq(64'b001, 3);
    check("t5_active_trunc", 32'(bus.rx_active), 32'h0);
    send_seq(64'b1111, 4);
    do_eop(1);
    settle();
    check("t5_no_bytes", 32'(byte_q.size() - b0), 32'd0);
    check("t5_no_pkt_end", 32'(pkt_end_n - p0), 32'd0);

    // Minimum SYNC: exactly three zeros then 1 is accepted.
    snap();
    send_seq(64'b0001, 4);
    check("t5b_active_min_sync", 32'(bus.rx_active), 32'h1);
    do_eop(1);
    settle();
    check("t5b_pkt_end", 32'(pkt_end_n - p0), 32'd1);
    check("t5b_align", 32'(align_n - a0), 32'd0);

    // Reset mid-byte, then a clean packet afterwards.
    snap();
    send_seq(64'b00000001, 8);
    send_seq(64'b1010, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur = LS_J;
    drive_line(LS_J);
    check("t6_outs_after_rst", 32'(outs_zero_vec()), 32'h0);
    settle();
    check("t6_no_pkt_end", 32'(pkt_end_n - p0), 32'd0);
    send_seq(64'b00000001, 8);
    send_seq(64'b10100101, 8);
    check("t6_byte_after_rst", 32'(bus.rx_byte), 32'hA5);
    do_eop(1);
    settle();

    // EOP coincident with a pulse: the ninth bit is dropped, so no alignment error.
    snap();
    send_seq(64'b00000001, 8);
    send_seq(64'b00110011, 8);
    send_bit(1'b0, 1'b1);
    check("t7_pkt_end", 32'(bus.rx_pkt_end), 32'h1);
    check("t7_align_dropped_bit", 32'(bus.rx_align_err), 32'h0);
    cur = LS_J;
    drive_line(LS_J);
    settle();
    check("t7_nbytes", 32'(byte_q.size() - b0), 32'd1);
    check("t7_active", 32'(bus.rx_active), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
